// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard-based hazard/flush controller for an in-order pipeline.
// Optional macro HAZARD_WB_BYPASS_EN: a same-cycle writeback to a source register does not stall.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_reg_write,
    input  logic [4:0]  id_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        ex_branch_taken,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic wb_hit_rs, wb_hit_rt;
    logic rs_hazard, rt_hazard, hazard;
    logic flushing, stall_cycle, issue;

    always_comb begin
        wb_hit_rs = 1'b0;
        wb_hit_rt = 1'b0;
`ifdef HAZARD_WB_BYPASS_EN
        // Register file writes before it reads, so the pending value is visible this cycle.
        wb_hit_rs = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs);
        wb_hit_rt = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt);
`endif
    end

    always_comb begin
        rs_hazard   = (id_rs != '0) && busy_q[id_rs] && !wb_hit_rs;
        rt_hazard   = id_uses_rt && (id_rt != '0) && busy_q[id_rt] && !wb_hit_rt;
        hazard      = id_valid && (rs_hazard || rt_hazard);
        flushing    = ex_branch_taken || (state_q == FLUSH);
        stall_cycle = hazard && !flushing;
        issue       = id_valid && !hazard && (state_q != FLUSH) && !ex_branch_taken;
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_reg_write && (wb_rd != '0)) begin
            busy_d[wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-register set takes priority.
        if (issue && id_reg_write && (id_rd != '0)) begin
            busy_d[id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_cycle && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN, STALL, FLUSH: begin
                if (ex_branch_taken) begin
                    state_d = FLUSH;
                end else if (hazard) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        if (!reset) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            if_id_flush    = 1'b1;
        end else if (flushing) begin
            id_ex_bubble   = 1'b1;
            if_id_flush    = 1'b1;
        end else if (hazard) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            busy_q        <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        busy_mask   = busy_q;
        stall_count = stall_count_q;
        state       = state_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: behavioural model feeds an expectation queue
// that is drained and compared against the DUT mid-cycle.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rt, id_reg_write, wb_reg_write, ex_branch_taken;
    logic [4:0]  id_rs, id_rt, id_rd, wb_rd;
    logic        pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;
    logic [1:0]  state;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_rd(id_rd),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .busy_mask(busy_mask), .stall_count(stall_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc, ifid, bub, fl;
        logic [31:0] busy;
        logic [15:0] cnt;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_busy;
    int          m_cnt;
    int          m_state;
    logic [31:0] n_busy;
    int          n_cnt;
    int          n_state;

    function automatic bit bypassed(input logic [4:0] r);
`ifdef HAZARD_WB_BYPASS_EN
        return wb_reg_write && (wb_rd == r) && (r != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        cmp("pc_write_en",    {31'd0, pc_write_en},    {31'd0, e.pc});
        cmp("if_id_write_en", {31'd0, if_id_write_en}, {31'd0, e.ifid});
        cmp("id_ex_bubble",   {31'd0, id_ex_bubble},   {31'd0, e.bub});
        cmp("if_id_flush",    {31'd0, if_id_flush},    {31'd0, e.fl});
        cmp("busy_mask",      busy_mask,               e.busy);
        cmp("stall_count",    {16'd0, stall_count},    {16'd0, e.cnt});
        cmp("state",          {30'd0, state},          {30'd0, e.st});
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.pc = 0; e.ifid = 0; e.bub = 1; e.fl = 1;
        e.busy = 32'd0; e.cnt = 16'd0; e.st = 2'd0;
        exp_q.push_back(e);
        m_busy = 32'd0; m_cnt = 0; m_state = 0;
    endtask

    // Drive one cycle of ID/WB inputs, predict, check mid-cycle, then advance the model at the edge.
    task automatic step(input bit v, input int rs, input int rt, input bit urt,
                        input bit rw, input int rd, input bit wbw, input int wbrd, input bit br);
        exp_t e;
        bit hz, fl, iss;
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_uses_rt = urt;
        id_reg_write = rw; id_rd = rd[4:0];
        wb_reg_write = wbw; wb_rd = wbrd[4:0]; ex_branch_taken = br;

        hz = v && (((rs != 0) && m_busy[rs] && !bypassed(rs[4:0])) ||
                   (urt && (rt != 0) && m_busy[rt] && !bypassed(rt[4:0])));
        fl = br || (m_state == 2);
        iss = v && !hz && !fl;

        e.pc   = fl ? 1'b1 : !hz;
        e.ifid = fl ? 1'b1 : !hz;
        e.bub  = fl || hz;
        e.fl   = fl;
        e.busy = m_busy;
        e.cnt  = m_cnt[15:0];
        e.st   = m_state[1:0];
        exp_q.push_back(e);

        n_busy = m_busy;
        if (wbw && wbrd != 0) n_busy[wbrd] = 1'b0;
        if (iss && rw && rd != 0) n_busy[rd] = 1'b1;
        n_cnt   = (hz && !fl && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        n_state = br ? 2 : (hz ? 1 : 0);

        #2;
        check_outputs();
        @(posedge clk);
        m_busy = n_busy; m_cnt = n_cnt; m_state = n_state;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_reg_write = 0; id_rd = 0; wb_reg_write = 0; wb_rd = 0; ex_branch_taken = 0;

        push_reset_exp();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Issue r3 write, then a dependent read stalls
        step(1, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Writeback of r3 in the same cycle as the dependent read
        step(1, 3, 0, 0, 0, 0, 1, 3, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // rt dependency matters only when rt is used
        step(1, 0, 0, 0, 1, 5, 0, 0, 0);
        step(1, 0, 5, 1, 0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0, 0, 0, 0);
        // Same-cycle issue and writeback on r5: set wins
        step(1, 0, 0, 0, 1, 5, 1, 5, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5, 0);
        idle();

        // Branch taken while a hazard is present; squashed write must not mark r8
        step(1, 0, 0, 0, 1, 7, 0, 0, 0);
        step(1, 7, 0, 0, 1, 8, 0, 0, 1);
        step(1, 0, 0, 0, 1, 9, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 7, 0);

        // Writes to r0 are ignored and r0 is never hazardous
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle();

        // Long stall on r9 saturates the counter; stalled write to r12 is squashed
        step(1, 0, 0, 0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 70000; i++) begin
            step(1, 9, 0, 0, 1, 12, 0, 0, 0);
        end

        // Asynchronous reset in the middle of the stall
        #1;
        reset = 1'b0;
        push_reset_exp();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        push_reset_exp();
        check_outputs();
        id_valid = 0; id_reg_write = 0;
        reset = 1'b1;
        idle();
        step(1, 9, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port id_valid  input  1  ID stage holds a valid instruction.
REQ-004 SHALL have ports id_rs, id_rt  input  5 each  ID source register addresses.
REQ-005 SHALL have port id_uses_rt  input  1  ID instruction reads rt.
REQ-006 SHALL have ports id_reg_write  input  1, id_rd  input  5  ID instruction destination (post reg_dst mux).
REQ-007 SHALL have ports wb_reg_write  input  1, wb_rd  input  5  register-file write occurring this cycle.
REQ-008 SHALL have port ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-009 SHALL have outputs pc_write_en  1, if_id_write_en  1  PC / IF_ID load enables.
REQ-010 SHALL have outputs id_ex_bubble  1 (zero ID_EX controls), if_id_flush  1 (clear IF_ID).
REQ-011 SHALL have outputs busy_mask  32  scoreboard; stall_count  16  stall-cycle counter; state  2  FSM state.

Function
REQ-012 SHALL keep scoreboard busy_mask, bit n = write to register n pending; bit 0 SHALL never set.
REQ-013 issue = id_valid & ~hazard & state!=FLUSH & ~ex_branch_taken; on issue with id_reg_write & id_rd!=0, bit id_rd SHALL set next edge.
REQ-014 wb_reg_write & wb_rd!=0 SHALL clear bit wb_rd next edge; simultaneous set and clear of same bit -> set wins.
REQ-015 hazard = id_valid & (busy[id_rs] | (id_uses_rt & busy[id_rt])), register 0 never hazardous; combinational, zero latency.
REQ-016 FSM states RUN=0, STALL=1, FLUSH=2; encoding 3 unused, SHALL return to RUN.
REQ-017 RUN/STALL: ex_branch_taken -> FLUSH; else hazard -> STALL; else -> RUN.
REQ-018 FLUSH SHALL last exactly one cycle, then RUN/STALL/FLUSH per REQ-017 rules.
REQ-019 Hazard cycle (no branch): pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, if_id_flush=0.
REQ-020 ex_branch_taken cycle or FLUSH state: pc_write_en=1, if_id_write_en=1, if_id_flush=1, id_ex_bubble=1; branch overrides hazard.
REQ-021 Otherwise pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0.
REQ-022 stall_count SHALL increment on each REQ-019 cycle, saturating at 16'hFFFF.
REQ-023 Squashed (non-issued) instructions SHALL NOT modify busy_mask.

Reset
REQ-024 reset=0 SHALL immediately force busy_mask=0, stall_count=0, state=RUN.
REQ-025 While reset=0: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, if_id_flush=1.
REQ-026 Reset asserted mid-stall or mid-flush SHALL abandon it; first cycle after release is RUN with empty scoreboard.

Configuration
REQ-027 Macro HAZARD_WB_BYPASS_EN defined: source equal to wb_rd with wb_reg_write=1 (nonzero) SHALL NOT count as hazard in that cycle (write-before-read register file).
REQ-028 Macro undefined: such a source SHALL stall that cycle; hazard clears the cycle after the busy bit clears.

Verification
REQ-029 Reset release, issue r3 write, next cycle ID reads rs=3 -> busy_mask=32'h8, pc_write_en=0, id_ex_bubble=1, state=STALL.
REQ-030 Busy r3, wb_reg_write=1 wb_rd=3 with ID rs=3 -> with macro no stall that cycle; without macro one stall cycle, issue next; stall_count differs by 1.
REQ-031 ex_branch_taken=1 while hazard present -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1, busy_mask unchanged, next state FLUSH, then RUN.
REQ-032 id_rd=0 with id_reg_write=1, then ID reads rs=0 -> busy_mask stays 0, no stall.
REQ-033 Same-cycle issue to r5 and wb clear of r5 -> busy_mask bit5=1 after edge.
REQ-034 Force 70000 stall cycles -> stall_count holds 16'hFFFF; assert reset mid-stall -> all outputs per REQ-025 without clock edge.
